// File: rtl/unit_cmd_responder_if.sv
// Control-packet, local-memory and compute-core signals seen by one processing unit's responder.
// slave is the responder side; master is the controller/memory/core side.
interface unit_cmd_responder_if #(
    parameter int CNT_W = 16
) ();
    logic [5:0]       ctrl_encoded;
    logic [7:0]       ctrl_data;
    logic             unit_ready;
    logic             unit_done;
    logic             mem_req;
    logic             mem_we;
    logic [6:0]       mem_addr;
    logic             mem_ack;
    logic             comp_start;
    logic [1:0]       comp_type;
    logic [3:0]       comp_len;
    logic             comp_done;
    logic             err_timeout;
    logic [CNT_W-1:0] cmd_count;

    modport slave (
        input  ctrl_encoded, ctrl_data, mem_ack, comp_done,
        output unit_ready, unit_done, mem_req, mem_we, mem_addr,
               comp_start, comp_type, comp_len, err_timeout, cmd_count
    );

    modport master (
        output ctrl_encoded, ctrl_data, mem_ack, comp_done,
        input  unit_ready, unit_done, mem_req, mem_we, mem_addr,
               comp_start, comp_type, comp_len, err_timeout, cmd_count
    );
endinterface

// File: rtl/unit_cmd_responder.sv
// Processing-unit endpoint: qualifies a control packet against UNIT_ID and sequences
// the commanded load/store beats or compute-core run, reporting ready/done status.
//
// state       | meaning
// IDLE        | ready, waiting for a packet addressed to this unit
// XFER        | issuing memory beats, one per mem_ack
// COMP_START  | single-cycle compute start pulse
// COMP_WAIT   | waiting for comp_done
// DONE        | one-cycle completion pulse, bump cmd_count
// HOLD        | wait for the controller to withdraw the packet
module unit_cmd_responder #(
    parameter logic [1:0] UNIT_ID        = 2'd0,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    unit_cmd_responder_if.slave  bus
);
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      OP_NOP   = 2'b00;
    localparam logic [1:0]      OP_STORE = 2'b10;
    localparam logic [1:0]      OP_COMP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_XFER, S_COMP_START, S_COMP_WAIT, S_DONE, S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       ctype_q, ctype_d;
    logic [3:0]       addr_q, addr_d;
    logic [3:0]       len_q, len_d;
    logic [2:0]       beat_q, beat_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic last_beat;
    logic tmo_hit;

    assign accept = (bus.ctrl_encoded[5:4] == UNIT_ID) &&
                    (bus.ctrl_encoded[3:2] != OP_NOP) &&
                    bus.ctrl_data[3];
    assign last_beat = ({1'b0, beat_q} == (len_q - 4'd1));
    assign tmo_hit   = (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ctype_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctype_q <= ctype_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctype_d = ctype_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = bus.ctrl_encoded[3:2];
                    ctype_d = bus.ctrl_encoded[1:0];
                    addr_d  = bus.ctrl_data[7:4];
                    len_d   = {1'b0, bus.ctrl_data[2:0]} + 4'd1;
                    beat_d  = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = (bus.ctrl_encoded[3:2] == OP_COMP) ? S_COMP_START : S_XFER;
                end
            end
            S_XFER: begin
                // Progress takes priority over an expiring timeout.
                if (bus.mem_ack) begin
                    tmo_d = '0;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_COMP_START: begin
                state_d = S_COMP_WAIT;
            end
            S_COMP_WAIT: begin
                if (bus.comp_done) begin
                    tmo_d   = '0;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // A packet still present after completion must not run twice.
                if (!accept) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.unit_ready  = (state_q == S_IDLE);
    assign bus.unit_done   = (state_q == S_DONE);
    assign bus.mem_req     = (state_q == S_XFER);
    assign bus.mem_we      = (state_q == S_XFER) && (op_q == OP_STORE);
    assign bus.mem_addr    = {addr_q, beat_q};
    assign bus.comp_start  = (state_q == S_COMP_START);
    assign bus.comp_type   = ctype_q;
    assign bus.comp_len    = len_q;
    assign bus.err_timeout = err_q;
    assign bus.cmd_count   = cnt_q;
endmodule

// File: tb/tb_unit_cmd_responder.sv
// Directed bench for unit_cmd_responder: a packet table run through load/store/compute
// flows, plus hand sequences for timeout, held packets, start/done overlap and reset.
module tb_unit_cmd_responder;
    typedef struct {
        logic [5:0] enc;
        logic [7:0] data;
        logic       acc;
        logic       is_comp;
        logic       we;
        logic [6:0] base;
        logic [3:0] len;
        logic [1:0] ctype;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   exp_cnt;
    vec_t vecs[8];

    unit_cmd_responder_if #(.CNT_W(16)) bus ();

    unit_cmd_responder #(
        .UNIT_ID(2'd2),
        .TIMEOUT_CYCLES(16),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called while the DUT is in DONE; finishes the command and returns it to IDLE.
    task automatic hold_tail(input string tag);
        chk({tag, "_done"}, 32'(bus.unit_done), 1);
        chk({tag, "_req_low"}, 32'(bus.mem_req), 0);
        exp_cnt++;
        bus.mem_ack   = 1'b0;
        bus.comp_done = 1'b0;
        step();
        chk({tag, "_done_1cyc"}, 32'(bus.unit_done), 0);
        chk({tag, "_count"}, 32'(bus.cmd_count), 32'(exp_cnt));
        chk({tag, "_hold_busy"}, 32'(bus.unit_ready), 0);
        bus.ctrl_encoded = 6'b10_00_00;
        step();
        chk({tag, "_ready_back"}, 32'(bus.unit_ready), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.ctrl_encoded = v.enc;
        bus.ctrl_data    = v.data;
        if (!v.acc) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk({tag, "_no_req"}, 32'(bus.mem_req), 0);
                chk({tag, "_no_start"}, 32'(bus.comp_start), 0);
                chk({tag, "_ready"}, 32'(bus.unit_ready), 1);
            end
            chk({tag, "_count_same"}, 32'(bus.cmd_count), 32'(exp_cnt));
            bus.ctrl_encoded = 6'd0;
            bus.ctrl_data    = 8'd0;
            return;
        end
        step();
        chk({tag, "_err_clr"}, 32'(bus.err_timeout), 0);
        chk({tag, "_busy"}, 32'(bus.unit_ready), 0);
        // Latched fields must ignore later packet changes; valid stays set.
        bus.ctrl_data = v.data ^ 8'hF0;
        if (!v.is_comp) begin
            bus.mem_ack = 1'b1;
            for (int b = 0; b < 32'(v.len); b++) begin
                chk({tag, "_req"}, 32'(bus.mem_req), 1);
                chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(v.base) + 32'(b));
                chk({tag, "_we"}, 32'(bus.mem_we), 32'(v.we));
                chk({tag, "_early_done"}, 32'(bus.unit_done), 0);
                step();
            end
        end else begin
            chk({tag, "_start"}, 32'(bus.comp_start), 1);
            chk({tag, "_ctype"}, 32'(bus.comp_type), 32'(v.ctype));
            chk({tag, "_clen"}, 32'(bus.comp_len), 32'(v.len));
            chk({tag, "_no_mem"}, 32'(bus.mem_req), 0);
            step();
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_start_1cyc"}, 32'(bus.comp_start), 0);
                chk({tag, "_wait"}, 32'(bus.unit_done), 0);
                chk({tag, "_ctype_hold"}, 32'(bus.comp_type), 32'(v.ctype));
                step();
            end
            bus.comp_done = 1'b1;
            step();
        end
        hold_tail(tag);
        bus.ctrl_data = 8'd0;
    endtask

    // STORE to addr 1, len 1, never acknowledged.
    task automatic tmo_seq(input string tag);
        bus.ctrl_encoded = 6'b10_10_00;
        bus.ctrl_data    = 8'h18;
        bus.mem_ack      = 1'b0;
        step();
        chk({tag, "_err_clr"}, 32'(bus.err_timeout), 0);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_req"}, 32'(bus.mem_req), 1);
            chk({tag, "_we"}, 32'(bus.mem_we), 1);
            step();
        end
        chk({tag, "_err_set"}, 32'(bus.err_timeout), 1);
        hold_tail(tag);
        chk({tag, "_err_sticky"}, 32'(bus.err_timeout), 1);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        exp_cnt = 0;
        vecs[0] = '{6'b10_01_00, 8'h5B, 1'b1, 1'b0, 1'b0, 7'h28, 4'd4, 2'd0};
        vecs[1] = '{6'b10_10_01, 8'hA8, 1'b1, 1'b0, 1'b1, 7'h50, 4'd1, 2'd1};
        vecs[2] = '{6'b10_01_11, 8'hFF, 1'b1, 1'b0, 1'b0, 7'h78, 4'd8, 2'd3};
        vecs[3] = '{6'b01_01_00, 8'h5B, 1'b0, 1'b0, 1'b0, 7'h00, 4'd0, 2'd0};
        vecs[4] = '{6'b10_01_00, 8'h53, 1'b0, 1'b0, 1'b0, 7'h00, 4'd0, 2'd0};
        vecs[5] = '{6'b10_00_00, 8'h5B, 1'b0, 1'b0, 1'b0, 7'h00, 4'd0, 2'd0};
        vecs[6] = '{6'b10_11_10, 8'h0F, 1'b1, 1'b1, 1'b0, 7'h00, 4'd8, 2'd2};
        vecs[7] = '{6'b10_11_01, 8'h39, 1'b1, 1'b1, 1'b0, 7'h00, 4'd2, 2'd1};

        rst_n            = 1'b0;
        bus.ctrl_encoded = 6'd0;
        bus.ctrl_data    = 8'd0;
        bus.mem_ack      = 1'b0;
        bus.comp_done    = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(bus.unit_ready), 1);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_start", 32'(bus.comp_start), 0);
        chk("rst_done", 32'(bus.unit_done), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
        chk("rst_count", 32'(bus.cmd_count), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_clen", 32'(bus.comp_len), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        tmo_seq("tmo1");
        run_vec(vecs[1], 101);

        // mem_ack arriving on the final timeout cycle counts as progress.
        bus.ctrl_encoded = 6'b10_10_00;
        bus.ctrl_data    = 8'h29;
        step();
        for (int i = 0; i < 15; i++) begin
            chk("pw_req", 32'(bus.mem_req), 1);
            chk("pw_addr0", 32'(bus.mem_addr), 32'h10);
            step();
        end
        bus.mem_ack = 1'b1;
        chk("pw_req_last", 32'(bus.mem_req), 1);
        step();
        chk("pw_still_xfer", 32'(bus.mem_req), 1);
        chk("pw_addr1", 32'(bus.mem_addr), 32'h11);
        chk("pw_no_err", 32'(bus.err_timeout), 0);
        chk("pw_not_done", 32'(bus.unit_done), 0);
        step();
        chk("pw_err_final", 32'(bus.err_timeout), 0);
        hold_tail("pw");

        // comp_done overlapping the start pulse is ignored.
        bus.ctrl_encoded = 6'b10_11_01;
        bus.ctrl_data    = 8'h08;
        step();
        chk("ov_start", 32'(bus.comp_start), 1);
        bus.comp_done = 1'b1;
        step();
        bus.comp_done = 1'b0;
        chk("ov_ignored", 32'(bus.unit_done), 0);
        chk("ov_start_off", 32'(bus.comp_start), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ov_wait", 32'(bus.unit_done), 0);
        end
        chk("ov_clen", 32'(bus.comp_len), 1);
        bus.comp_done = 1'b1;
        step();
        hold_tail("ov");

        // Packet left asserted after completion runs exactly once.
        bus.ctrl_encoded = 6'b10_10_01;
        bus.ctrl_data    = 8'hA8;
        step();
        bus.mem_ack = 1'b1;
        chk("hd_addr", 32'(bus.mem_addr), 32'h50);
        step();
        bus.mem_ack = 1'b0;
        chk("hd_done", 32'(bus.unit_done), 1);
        exp_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("hd_busy", 32'(bus.unit_ready), 0);
            chk("hd_no_req", 32'(bus.mem_req), 0);
            chk("hd_no_done", 32'(bus.unit_done), 0);
        end
        chk("hd_count_once", 32'(bus.cmd_count), 32'(exp_cnt));
        bus.ctrl_data = 8'hA0;
        step();
        chk("hd_idle", 32'(bus.unit_ready), 1);
        bus.ctrl_data = 8'hA8;
        step();
        chk("hd_rerun", 32'(bus.mem_req), 1);
        bus.mem_ack = 1'b1;
        step();
        hold_tail("hd2");

        // Reset clears the sticky error and the counter.
        tmo_seq("tmo2");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(bus.err_timeout), 0);
        chk("rst2_count", 32'(bus.cmd_count), 0);
        exp_cnt = 0;
        step();
        rst_n = 1'b1;
        step();

        // Asynchronous reset in the middle of a transfer.
        bus.ctrl_encoded = vecs[0].enc;
        bus.ctrl_data    = vecs[0].data;
        step();
        bus.mem_ack = 1'b1;
        step();
        step();
        chk("rx_addr_b2", 32'(bus.mem_addr), 32'h2A);
        chk("rx_req_pre", 32'(bus.mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rx_req_async", 32'(bus.mem_req), 0);
        chk("rx_no_done", 32'(bus.unit_done), 0);
        chk("rx_ready", 32'(bus.unit_ready), 1);
        bus.mem_ack      = 1'b0;
        bus.ctrl_encoded = 6'd0;
        bus.ctrl_data    = 8'd0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rx_ready_after", 32'(bus.unit_ready), 1);
        chk("rx_count", 32'(bus.cmd_count), 0);
        chk("rx_err", 32'(bus.err_timeout), 0);
        chk("rx_no_done_after", 32'(bus.unit_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
